// File: rtl/rr_mux_arbiter_32.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_32
//
// Round-robin arbiter that shares one 32:1 selection mux among 32
// requesters. It produces a registered one-hot grant and the matching 5-bit
// select, which drives the mux S input directly.
//
// Operation:
//   IDLE : when any request is present, the winner is the first set request
//          bit found by searching from the priority pointer upward, with
//          wrap-around. The grant and select are registered and the arbiter
//          moves to BUSY.
//   BUSY : the grant is held until DONE, until the granted requester
//          withdraws, or (optional feature) until the hold limit is reached.
//          On release the pointer moves to (winner + 1) mod 32 and the
//          arbiter returns to IDLE. As a result, VALID is always low for
//          exactly one cycle between consecutive grants.
//   SEL keeps the last winner while idle, so the mux output stays stable.
//
// Ports:
//   clk_i      : system clock; all state updates on rising edge
//   rst_ni     : asynchronous active-low reset
//   req_i      : request vector; bit i = requester i wants the mux
//   done_i     : consumer finished with the current grant (used only in BUSY)
//   gnt_o      : registered one-hot grant; zero when idle
//   sel_o      : registered mux select (index of current/last winner)
//   valid_o    : high while a grant is active (== |gnt_o)
//   timeout_o  : one-cycle pulse after a forced release (optional feature)
//
// Parameters:
//   HOLD_MAX   : maximum number of BUSY cycles before a forced release
//                (1..255). Only used when ARB_HOLD_LIMIT_EN is defined.
//
// Configuration macro:
//   ARB_HOLD_LIMIT_EN : when defined, enables the 8-bit hold counter and the
//                       forced release with the timeout_o pulse. When
//                       undefined, a grant is held indefinitely and
//                       timeout_o is constant 0.
// ---------------------------------------------------------------------------
module rr_mux_arbiter_32 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] req_i,
  input  logic        done_i,
  output logic [31:0] gnt_o,
  output logic [4:0]  sel_o,
  output logic        valid_o,
  output logic        timeout_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Elaboration-time guard: the hold counter is 8 bits wide.
  if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_hold_max_range
    $error("rr_mux_arbiter_32: HOLD_MAX must be within 1..255");
  end

  // Returns the index of the lowest set bit (0 when no bit is set).
  function automatic logic [4:0] first_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] gnt_q, gnt_d;
  logic [4:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [4:0]  ptr_q, ptr_d;

  logic [31:0] req_rot_s;
  logic [4:0]  winner_s;
  logic        limit_s;
  logic        release_s;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [8:0] HOLD_MAX_W = 9'(HOLD_MAX);

  logic [7:0] hold_cnt_q, hold_cnt_d;

  // The limit is reached on the BUSY edge that would complete the HOLD_MAX-th
  // BUSY cycle, so the grant is visible for exactly HOLD_MAX cycles.
  always_comb begin
    limit_s = (({1'b0, hold_cnt_q} + 9'd1) >= HOLD_MAX_W);
  end
`else
  // Without the hold-limit feature the grant can only end by DONE or withdraw.
  always_comb begin
    limit_s = 1'b0;
  end
`endif

  // Rotate the request vector so that bit 0 corresponds to the pointer
  // position. The lowest set bit of the rotated vector then gives the
  // offset of the winner from the pointer.
  always_comb begin
    req_rot_s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      req_rot_s[i] = req_i[5'(i) + ptr_q];
    end
    winner_s = ptr_q + first_set_idx(req_rot_s);
  end

  // Next-state and output logic of the IDLE/BUSY controller.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    release_s = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_i != 32'd0) begin
          gnt_d   = 32'd1 << winner_s;
          sel_d   = winner_s;
          valid_d = 1'b1;
          state_d = ST_BUSY;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d = 8'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // DONE, withdraw and limit together still form a single release.
        release_s = done_i | ~req_i[sel_q] | limit_s;
        if (release_s) begin
          gnt_d     = 32'd0;
          valid_d   = 1'b0;
          ptr_d     = sel_q + 5'd1;
          state_d   = ST_IDLE;
          // Only flag a timeout when the limit alone ended the grant.
          timeout_d = limit_s & ~done_i & req_i[sel_q];
        end else begin
          state_d = ST_BUSY;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 32'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 32'd0;
      sel_q     <= 5'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Hold counter: cleared on entry to BUSY, counts BUSY cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter_32.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter_32
//
// Self-checking bench for rr_mux_arbiter_32. A table of directed vectors
// ({req, done} applied before an edge, {gnt, sel, valid, timeout} expected
// after it) covers single-requester hold, rotation with wrap, DONE ignored
// in IDLE, withdraw, and pointer updates. Hand-written sequences cover reset,
// mid-grant asynchronous reset and the hold limit.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        done;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        valid;
  logic        timeout;

  int checks;
  int errors;

  rr_mux_arbiter_32 #(.HOLD_MAX(4)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .valid_o   (valid),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic        done;
    logic [31:0] exp_gnt;
    logic [4:0]  exp_sel;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [31:0] eg, input logic [4:0] es,
                         input logic ev, input logic et);
    chk({nm, " gnt"}, gnt, eg);
    chk({nm, " sel"}, {27'd0, sel}, {27'd0, es});
    chk({nm, " valid"}, {31'd0, valid}, {31'd0, ev});
    chk({nm, " timeout"}, {31'd0, timeout}, {31'd0, et});
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Starting state for the table: IDLE, PTR=1, SEL=0.
    vecs[0]  = '{32'h0000_0400, 1'b0, 32'h0000_0400, 5'd10, 1'b1}; // grant 10
    vecs[1]  = '{32'h0000_0400, 1'b0, 32'h0000_0400, 5'd10, 1'b1};
    vecs[2]  = '{32'h0000_0400, 1'b0, 32'h0000_0400, 5'd10, 1'b1};
    vecs[3]  = '{32'h0000_0400, 1'b1, 32'h0000_0000, 5'd10, 1'b0}; // DONE -> PTR=11
    vecs[4]  = '{32'h0000_0401, 1'b0, 32'h0000_0001, 5'd0,  1'b1}; // from 11 wraps to 0
    vecs[5]  = '{32'h0000_0401, 1'b1, 32'h0000_0000, 5'd0,  1'b0}; // PTR=1
    vecs[6]  = '{32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1};
    vecs[7]  = '{32'h8000_0001, 1'b1, 32'h0000_0000, 5'd31, 1'b0}; // PTR wraps to 0
    vecs[8]  = '{32'h8000_0001, 1'b0, 32'h0000_0001, 5'd0,  1'b1};
    vecs[9]  = '{32'h8000_0001, 1'b1, 32'h0000_0000, 5'd0,  1'b0};
    vecs[10] = '{32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1};
    vecs[11] = '{32'h8000_0001, 1'b1, 32'h0000_0000, 5'd31, 1'b0}; // PTR=0
    vecs[12] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b0}; // DONE in IDLE ignored
    vecs[13] = '{32'h0000_0020, 1'b0, 32'h0000_0020, 5'd5,  1'b1}; // grant 5
    vecs[14] = '{32'h0000_0028, 1'b0, 32'h0000_0020, 5'd5,  1'b1}; // bit 3 ignored in BUSY
    vecs[15] = '{32'h0000_0008, 1'b0, 32'h0000_0000, 5'd5,  1'b0}; // withdraw -> PTR=6
    vecs[16] = '{32'h0000_0008, 1'b0, 32'h0000_0008, 5'd3,  1'b1}; // 3 granted in IDLE
    vecs[17] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd3,  1'b0}; // DONE+withdraw, PTR=4
    vecs[18] = '{32'h0000_0018, 1'b0, 32'h0000_0010, 5'd4,  1'b1};
    vecs[19] = '{32'h0000_0018, 1'b1, 32'h0000_0000, 5'd4,  1'b0}; // PTR=5
    vecs[20] = '{32'h0000_0018, 1'b0, 32'h0000_0008, 5'd3,  1'b1}; // 5..31 empty, wrap to 3
    vecs[21] = '{32'h0000_0018, 1'b1, 32'h0000_0000, 5'd3,  1'b0}; // PTR=4

    // Reset with all requests asserted.
    rst_n = 1'b0;
    req   = 32'hFFFF_FFFF;
    done  = 1'b0;
    step();
    step();
    chk_out("reset", 32'h0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("post-reset grant", 32'h1, 5'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("post-reset release", 32'h0, 5'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 32'h0;

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_sel, vecs[i].exp_valid, 1'b0);
    end
    done = 1'b0;

    // Mid-grant asynchronous reset while SEL=20.
    req = 32'h0010_0000;
    step();
    chk_out("grant 20", 32'h0010_0000, 5'd20, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 32'h0, 5'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    req   = 32'h0010_0004;
    step();
    chk_out("search from 0", 32'h0000_0004, 5'd2, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_out("release 2", 32'h0, 5'd2, 1'b0, 1'b0);
    done = 1'b0;

    // Hold behaviour with DONE low and the request held.
    req = 32'h0000_0080;
    step();
    chk_out("hold grant", 32'h0000_0080, 5'd7, 1'b1, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("hold cyc%0d", i + 1), 32'h0000_0080, 5'd7, 1'b1, 1'b0);
    end
    step();
    chk_out("forced release", 32'h0, 5'd7, 1'b0, 1'b1);
    req = 32'h0000_0081;
    step();
    chk_out("after timeout", 32'h0000_0001, 5'd0, 1'b1, 1'b0);
`else
    for (int i = 0; i < 120; i++) begin
      step();
      chk($sformatf("hold gnt cyc%0d", i), gnt, 32'h0000_0080);
      chk($sformatf("hold timeout cyc%0d", i), {31'd0, timeout}, 32'd0);
    end
    req = 32'h0000_0081;
    done = 1'b1;
    step();
    chk_out("hold done", 32'h0, 5'd7, 1'b0, 1'b0);
    done = 1'b0;
    step();
    chk_out("after hold", 32'h0000_0001, 5'd0, 1'b1, 1'b0);
`endif
    done = 1'b1;
    step();
    chk_out("final release", 32'h0, 5'd0, 1'b0, 1'b0);
    chk("valid==|gnt", {31'd0, valid}, {31'd0, |gnt});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_32.md
Name: rr_mux_arbiter_32

Overview:
- Round-robin arbiter that shares one 32:1 selection mux (MUX1_32x1 / 32-bit-wide variants) among 32 requesters.
- Produces a registered one-hot grant and the matching 5-bit select that drives the mux S input directly.
- Sits between the requesting units (register-file read clients, bus masters) and the shared mux/consumer.
- Grant is held until the consumer signals DONE or the requester withdraws.

Parameters:
- HOLD_MAX, 16: maximum cycles a grant may stay in BUSY before forced release. Range 1..255. Used only when ARB_HOLD_LIMIT_EN is defined.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- REQ  input  32  request vector; bit i = requester i wants the mux
- DONE  input  1  consumer has finished with the current grant; sampled only in BUSY
- GNT  output  32  registered one-hot grant; all zero when idle
- SEL  output  5  registered mux select = index of current/last winner
- VALID  output  1  high while a grant is active (GNT != 0)
- TIMEOUT  output  1  one-cycle pulse on forced release (feature-dependent)

Behaviour:
- Reset (RST=0, takes effect immediately without a clock edge):
  - GNT=0, SEL=0, VALID=0, TIMEOUT=0
  - Priority pointer PTR=0; state IDLE; hold counter=0
  - Asserting reset mid-grant drops the grant immediately.
- States: IDLE, BUSY.
- IDLE, on a rising edge with REQ != 0:
  - Winner w = first set REQ bit, searching indices PTR, PTR+1, ... 31, 0, ... PTR-1 (mod 32).
  - Register GNT = 1<<w, SEL = w, VALID = 1; go to BUSY.
  - Latency: REQ present before edge k gives GNT/SEL valid after edge k (1 cycle).
- IDLE with REQ == 0: all outputs hold; SEL keeps the last winner so the mux output stays stable.
- BUSY, release condition at an edge: DONE=1, or REQ[SEL]=0, or (feature on) hold count reaches HOLD_MAX.
  - DONE and withdraw together count as a single release.
  - On release: GNT=0, VALID=0, PTR = SEL+1 mod 32 (31 wraps to 0), state IDLE. SEL is unchanged.
- Turnaround: there is always exactly one IDLE cycle between consecutive grants (VALID low for 1 cycle). This is fixed behaviour.
- In BUSY, changes on non-granted REQ bits are ignored. New arbitration uses REQ as sampled in IDLE.
- DONE is ignored in IDLE.
- Fairness: a requester that keeps REQ asserted is granted within 31 other grants.
- GNT is always one-hot or zero; VALID == |GNT at all times.

Optional Feature:
- Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - 8-bit hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches HOLD_MAX with no other release, the grant is force-released: same PTR update as a normal release.
  - TIMEOUT=1 for the cycle after the forced-release edge, then returns to 0.
  - If DONE arrives on the same edge the limit is reached, it is a normal release and TIMEOUT stays 0.
- Undefined: no counter; grant is held indefinitely; TIMEOUT tied 0.

Test Plan:
- Reset: RST=0 with REQ=32'hFFFFFFFF -> GNT=0, SEL=0, VALID=0. Release reset, next edge -> GNT=32'h1, SEL=0.
- Single requester: REQ=32'h0000_0400, DONE pulsed 3 cycles after grant -> SEL=10, GNT=32'h400 for 3 cycles, then VALID=0 and PTR=11.
- Rotation/wrap: REQ=32'h8000_0001 held, DONE pulsed each grant -> SEL sequence 0,31,0,31 with one idle cycle between grants.
- Withdraw: grant to 5; REQ[5] drops while DONE=0 -> release on that edge. REQ bit 3 set during BUSY is not granted until the IDLE cycle.
- Mid-operation reset: RST pulsed low while SEL=20, VALID=1 -> outputs zero immediately. Next grant search starts at 0.
- ARB_HOLD_LIMIT_EN with HOLD_MAX=4: REQ[7] held, DONE=0 -> GNT released after 4 BUSY cycles, TIMEOUT=1 for 1 cycle, PTR=8. Without the macro, the grant persists 100+ cycles and TIMEOUT=0.
